// File: rtl/spdif_frame_sched_if.sv
// spdif_frame_sched_if: sample-input, serializer-handshake and status bundle for spdif_frame_sched
// master: audio source / serializer side; slave: the scheduler
interface spdif_frame_sched_if #(parameter int DW = 24);
  logic ien;
  logic [DW-1:0] ich_data;
  logic ich_num;
  logic ich_data_valid;
  logic [31:0] icstat;
  logic iclr_err;
  logic [DW-1:0] osf_data;
  logic [1:0] osf_pre;
  logic osf_v;
  logic osf_cs;
  logic osf_req;
  logic isf_ack;
  logic [7:0] ofrm_cnt;
  logic ooverrun;
  logic ounderrun;
  modport master (
    output ien, ich_data, ich_num, ich_data_valid, icstat, iclr_err, isf_ack,
    input osf_data, osf_pre, osf_v, osf_cs, osf_req, ofrm_cnt, ooverrun, ounderrun
  );
  modport slave (
    input ien, ich_data, ich_num, ich_data_valid, icstat, iclr_err, isf_ack,
    output osf_data, osf_pre, osf_v, osf_cs, osf_req, ofrm_cnt, ooverrun, ounderrun
  );
endinterface

// File: rtl/spdif_frame_sched.sv
// spdif_frame_sched: buffers L/R samples and issues S/PDIF subframes (data, preamble, V, C) to a serializer
// iclk/irst: clock and async active-high reset
// bus: sample strobes in, subframe req/ack handshake out, frame counter and sticky error flags
module spdif_frame_sched #(
  parameter int DW = 24,
  parameter int BLOCK_LEN = 192
) (
  input logic iclk,
  input logic irst,
  spdif_frame_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEL_L, REQ_L, SEL_R, REQ_R} state_t;
  state_t st, nxt;
  logic [DW-1:0] h0 [2];
  logic [DW-1:0] h1 [2];
  logic [DW-1:0] last [2];
  logic [1:0] cnt [2];
  logic [1:0] push, pop, wr;
  logic sel, ch, ov, ud, flush, req;
  logic [DW-1:0] data;
  logic [1:0] pre;
  logic v, cs, ovf, udf;
  logic [7:0] frm;
  always_comb begin
    nxt = st;
    push = '0;
    pop = '0;
    wr = '0;
    unique case (st)
      IDLE:    nxt = bus.ien ? SEL_L : IDLE;
      SEL_L:   nxt = REQ_L;
      REQ_L:   nxt = bus.isf_ack ? SEL_R : REQ_L;
      SEL_R:   nxt = REQ_R;
      REQ_R:   nxt = bus.isf_ack ? (bus.ien ? SEL_L : IDLE) : REQ_R;
      default: nxt = IDLE;
    endcase
    sel = st == SEL_L || st == SEL_R;
    ch = st == SEL_R;
    req = st == REQ_L || st == REQ_R;
    flush = st == IDLE && !bus.ien;
    for (int c = 0; c < 2; c++) begin
      push[c] = bus.ich_data_valid && bus.ien && bus.ich_num == 1'(c);
      pop[c] = sel && ch == 1'(c) && cnt[c] != 2'd0;
      // a full FIFO still accepts when its head leaves in the same cycle
      wr[c] = push[c] && (cnt[c] != 2'd2 || pop[c]);
    end
    ov = |(push & ~wr);
    ud = sel && cnt[ch] == 2'd0;
  end
  always_ff @(posedge iclk or posedge irst)
    if (irst) st <= IDLE;
    else st <= nxt;
  // two-entry shift FIFOs: h0 is the head; a write lands in the slot left free after any pop
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      for (int c = 0; c < 2; c++) begin
        cnt[c] <= '0;
        h0[c] <= '0;
        h1[c] <= '0;
        last[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (pop[c]) begin
          h0[c] <= h1[c];
          last[c] <= h0[c];
        end
        if (wr[c] && cnt[c] - 2'(pop[c]) == 2'd0) h0[c] <= bus.ich_data;
        if (wr[c] && cnt[c] - 2'(pop[c]) == 2'd1) h1[c] <= bus.ich_data;
        cnt[c] <= flush ? 2'd0 : cnt[c] - 2'(pop[c]) + 2'(wr[c]);
      end
    end
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      data <= '0;
      pre <= '0;
      v <= 1'b0;
      cs <= 1'b0;
      frm <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ov || (ovf && !bus.iclr_err);
      udf <= ud || (udf && !bus.iclr_err);
      if (sel) begin
        data <= pop[ch] ? h0[ch] : last[ch];
        v <= !pop[ch];
        pre <= ch ? 2'b10 : (frm == 8'd0 ? 2'b00 : 2'b01);
        cs <= frm < 8'd32 && bus.icstat[frm[4:0]];
      end
      if (st == REQ_R && bus.isf_ack) frm <= frm == 8'(BLOCK_LEN - 1) ? 8'd0 : frm + 8'd1;
      else if (flush) frm <= '0;
    end
  assign bus.osf_data = data;
  assign bus.osf_pre = pre;
  assign bus.osf_v = v;
  assign bus.osf_cs = cs;
  assign bus.osf_req = req;
  assign bus.ofrm_cnt = frm;
  assign bus.ooverrun = ovf;
  assign bus.ounderrun = udf;
endmodule

// File: tb/tb_spdif_frame_sched.sv
// tb_spdif_frame_sched: directed and randomized self-checking bench for spdif_frame_sched
module tb_spdif_frame_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] cstat;
  logic [23:0] ql[$];
  logic [23:0] qr[$];
  logic [23:0] mlast [2];
  int mfrm;
  logic mov, mud;
  spdif_frame_sched_if #(.DW(24)) bus();
  spdif_frame_sched #(.DW(24), .BLOCK_LEN(192)) dut (.iclk(clk), .irst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic c, input logic [23:0] d);
    bus.ich_num = c;
    bus.ich_data = d;
    bus.ich_data_valid = 1'b1;
    tick();
    bus.ich_data_valid = 1'b0;
  endtask
  task automatic ack();
    bus.isf_ack = 1'b1;
    tick();
    bus.isf_ack = 1'b0;
  endtask
  task automatic sub(input string tag, input logic [23:0] d, input logic [1:0] p, input logic v);
    chk({tag, "_req"}, 32'(bus.osf_req), 32'd1);
    chk({tag, "_data"}, 32'(bus.osf_data), 32'(d));
    chk({tag, "_pre"}, 32'(bus.osf_pre), 32'(p));
    chk({tag, "_v"}, 32'(bus.osf_v), 32'(v));
  endtask
  task automatic serve(input logic c);
    logic [23:0] ed, pd;
    logic ev, pc;
    int n;
    for (int i = 0; i < 8 && !bus.osf_req; i++) tick();
    chk("rnd_req", 32'(bus.osf_req), 32'd1);
    if (c == 1'b0 && ql.size() > 0) begin
      ed = ql.pop_front();
      ev = 1'b0;
    end else if (c == 1'b1 && qr.size() > 0) begin
      ed = qr.pop_front();
      ev = 1'b0;
    end else begin
      ed = mlast[c];
      ev = 1'b1;
      mud = 1'b1;
    end
    mlast[c] = ed;
    chk("rnd_data", 32'(bus.osf_data), 32'(ed));
    chk("rnd_v", 32'(bus.osf_v), 32'(ev));
    chk("rnd_pre", 32'(bus.osf_pre), c ? 32'd2 : (mfrm == 0 ? 32'd0 : 32'd1));
    chk("rnd_cs", 32'(bus.osf_cs), mfrm < 32 ? 32'(cstat[mfrm]) : 32'd0);
    chk("rnd_frm", 32'(bus.ofrm_cnt), 32'(mfrm));
    chk("rnd_ovf", 32'(bus.ooverrun), 32'(mov));
    chk("rnd_udf", 32'(bus.ounderrun), 32'(mud));
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      pc = 1'($urandom_range(0, 1));
      pd = 24'($urandom);
      push(pc, pd);
      if (pc) begin
        if (qr.size() < 2) qr.push_back(pd);
        else mov = 1'b1;
      end else begin
        if (ql.size() < 2) ql.push_back(pd);
        else mov = 1'b1;
      end
    end
    if ($urandom_range(0, 7) == 0) begin
      bus.iclr_err = 1'b1;
      tick();
      bus.iclr_err = 1'b0;
      mov = 1'b0;
      mud = 1'b0;
    end
    repeat ($urandom_range(0, 2)) tick();
    chk("rnd_hold", 32'(bus.osf_data), 32'(ed));
    ack();
    chk("rnd_req_drop", 32'(bus.osf_req), 32'd0);
    if (c) mfrm = (mfrm + 1) % 192;
  endtask
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      serve(1'b0);
      serve(1'b1);
    end
  endtask
  initial begin
    bus.ien = 1'b0;
    bus.ich_data = '0;
    bus.ich_num = 1'b0;
    bus.ich_data_valid = 1'b0;
    bus.iclr_err = 1'b0;
    bus.isf_ack = 1'b0;
    cstat = 32'h1;
    bus.icstat = cstat;
    tick();
    tick();
    chk("rst_data", 32'(bus.osf_data), 32'd0);
    chk("rst_pre", 32'(bus.osf_pre), 32'd0);
    chk("rst_v", 32'(bus.osf_v), 32'd0);
    chk("rst_cs", 32'(bus.osf_cs), 32'd0);
    chk("rst_req", 32'(bus.osf_req), 32'd0);
    chk("rst_frm", 32'(bus.ofrm_cnt), 32'd0);
    chk("rst_ovf", 32'(bus.ooverrun), 32'd0);
    chk("rst_udf", 32'(bus.ounderrun), 32'd0);
    rst = 1'b0;
    bus.ien = 1'b1;
    push(1'b0, 24'h123456);
    chk("lat_n1_req", 32'(bus.osf_req), 32'd0);
    push(1'b1, 24'hABCDEF);
    sub("pair_l", 24'h123456, 2'b00, 1'b0);
    chk("pair_l_cs", 32'(bus.osf_cs), 32'd1);
    tick();
    ack();
    chk("ack_drop", 32'(bus.osf_req), 32'd0);
    tick();
    sub("pair_r", 24'hABCDEF, 2'b10, 1'b0);
    chk("pair_r_cs", 32'(bus.osf_cs), 32'd1);
    push(1'b0, 24'h000010);
    ack();
    chk("pair_frm", 32'(bus.ofrm_cnt), 32'd1);
    tick();
    sub("f1_l", 24'h000010, 2'b01, 1'b0);
    chk("f1_l_cs", 32'(bus.osf_cs), 32'd0);
    ack();
    tick();
    sub("f1_r_under", 24'hABCDEF, 2'b10, 1'b1);
    chk("f1_r_udf", 32'(bus.ounderrun), 32'd1);
    ack();
    tick();
    sub("f2_l_under", 24'h000010, 2'b01, 1'b1);
    chk("f2_l_udf", 32'(bus.ounderrun), 32'd1);
    push(1'b0, 24'h0000A1);
    push(1'b0, 24'h0000A2);
    chk("ovf_two", 32'(bus.ooverrun), 32'd0);
    push(1'b0, 24'h0000A3);
    chk("ovf_three", 32'(bus.ooverrun), 32'd1);
    bus.iclr_err = 1'b1;
    tick();
    bus.iclr_err = 1'b0;
    chk("clr_ovf", 32'(bus.ooverrun), 32'd0);
    chk("clr_udf", 32'(bus.ounderrun), 32'd0);
    bus.ien = 1'b0;
    ack();
    tick();
    sub("stop_r", 24'hABCDEF, 2'b10, 1'b1);
    ack();
    chk("stop_req0", 32'(bus.osf_req), 32'd0);
    tick();
    chk("stop_frm", 32'(bus.ofrm_cnt), 32'd0);
    repeat (3) tick();
    chk("stop_req_idle", 32'(bus.osf_req), 32'd0);
    bus.ien = 1'b1;
    tick();
    tick();
    chk("midrst_req_pre", 32'(bus.osf_req), 32'd1);
    bus.isf_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus.osf_req), 32'd0);
    chk("midrst_data", 32'(bus.osf_data), 32'd0);
    chk("midrst_pre", 32'(bus.osf_pre), 32'd0);
    chk("midrst_v", 32'(bus.osf_v), 32'd0);
    chk("midrst_cs", 32'(bus.osf_cs), 32'd0);
    chk("midrst_frm", 32'(bus.ofrm_cnt), 32'd0);
    chk("midrst_udf", 32'(bus.ounderrun), 32'd0);
    tick();
    rst = 1'b0;
    bus.isf_ack = 1'b0;
    tick();
    tick();
    sub("postrst_l", 24'h000000, 2'b00, 1'b1);
    chk("postrst_frm", 32'(bus.ofrm_cnt), 32'd0);
    bus.ien = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ql.delete();
    qr.delete();
    mlast[0] = '0;
    mlast[1] = '0;
    mfrm = 0;
    mov = 1'b0;
    mud = 1'b0;
    cstat = 32'h0000_0005;
    bus.icstat = cstat;
    bus.ien = 1'b1;
    run_frames(200);
    cstat = $urandom;
    bus.icstat = cstat;
    run_frames(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spdif_frame_sched.md
SPDIF_FRAME_SCHED -- requirements
Module: spdif_frame_sched

Interface
REQ-001 Parameter DW, default 24: audio sample width in bits.
REQ-002 Parameter BLOCK_LEN, default 192: frames per S/PDIF block.
REQ-003 iclk  input  1  sole clock; all state changes on rising edge.
REQ-004 irst  input  1  reset, asynchronous, active-high.
REQ-005 ien  input  1  scheduler enable.
REQ-006 ich_data  input  DW  incoming channel sample.
REQ-007 ich_num  input  1  channel of ich_data (0 = left, 1 = right).
REQ-008 ich_data_valid  input  1  ich_data/ich_num valid this cycle; single-cycle strobe, no backpressure.
REQ-009 icstat  input  32  channel-status bits for frames 0..31 of each block.
REQ-010 iclr_err  input  1  clears sticky error flags.
REQ-011 osf_data  output  DW  subframe sample to serializer.
REQ-012 osf_pre  output  2  preamble (00 = B, 01 = M, 10 = W).
REQ-013 osf_v  output  1  validity bit (1 = sample not valid, underrun repeat).
REQ-014 osf_cs  output  1  channel-status bit for the current frame.
REQ-015 osf_req  output  1  subframe request to serializer.
REQ-016 isf_ack  input  1  serializer accepted the current subframe.
REQ-017 ofrm_cnt  output  8  frame index within block, 0..BLOCK_LEN-1.
REQ-018 ooverrun, ounderrun  output  1 each  sticky error flags.

Function
REQ-019 Two FIFOs (left, right), each 2 entries deep, DW wide; a strobe pushes into FIFO[ich_num] only while ien=1.
REQ-020 Push into a full FIFO: sample dropped, ooverrun set; push and pop on the same full FIFO in the same cycle: both occur, no overrun.
REQ-021 FSM states IDLE, SEL_L, REQ_L, SEL_R, REQ_R.
REQ-022 IDLE -> SEL_L when ien=1; every other state is left only per REQ-023..REQ-025.
REQ-023 SEL_x (one cycle): FIFO non-empty -> pop head into osf_data, osf_v=0; empty -> osf_data holds last sample sent on that channel (0 after reset), osf_v=1, ounderrun set; then -> REQ_x.
REQ-024 REQ_x: osf_req=1, osf_data/osf_pre/osf_v/osf_cs stable; on the first cycle with isf_ack=1, REQ_L -> SEL_R, REQ_R -> SEL_L (ien=1) or IDLE (ien=0); osf_req deasserts the cycle after ack is sampled.
REQ-025 ien dropping mid-frame does not abort: the current left/right pair completes, then IDLE.
REQ-026 osf_pre: left and ofrm_cnt=0 -> B; left otherwise -> M; right -> W.
REQ-027 osf_cs = icstat[ofrm_cnt] when ofrm_cnt<32, else 0; same value on both subframes of a frame; icstat is sampled in SEL_x.
REQ-028 ofrm_cnt increments on ack in REQ_R; wraps BLOCK_LEN-1 -> 0.
REQ-029 isf_ack outside REQ_x is ignored.
REQ-030 Latency: ien rise in cycle N -> osf_req=1 from cycle N+2; ack in cycle M -> next osf_req=1 from cycle M+2.
REQ-031 iclr_err clears both flags; a new error event in the same cycle wins (flag stays 1).

Reset
REQ-032 irst=1 asynchronously forces IDLE, FIFOs empty, osf_data=0, osf_pre=00, osf_v=0, osf_cs=0, osf_req=0, ofrm_cnt=0, ooverrun=0, ounderrun=0, last-sample registers=0.
REQ-033 In IDLE with ien=0: FIFOs flushed, ofrm_cnt=0; other outputs hold.
REQ-034 Reset asserted mid-handshake drops osf_req immediately; no ack is consumed after release.

Verification
REQ-035 Push L=0x123456, R=0xABCDEF, ien=1, ack one cycle after each req -> subframes (0x123456, B, v=0), (0xABCDEF, W, v=0); ofrm_cnt=1.
REQ-036 Run 192 frames with icstat=0x00000005 -> osf_cs=1 only in frames 0 and 2; B on frames 0 and 192 (wrapped); M otherwise; ofrm_cnt wraps 191->0.
REQ-037 Three left pushes without a pop -> third dropped, ooverrun=1; iclr_err -> 0.
REQ-038 Left FIFO empty at SEL_L after prior sample 0x000010 -> osf_data=0x000010, osf_v=1, ounderrun=1.
REQ-039 ien cleared during REQ_L -> right subframe still issued, then IDLE, ofrm_cnt=0, osf_req stays 0.
REQ-040 irst pulsed while osf_req=1 and isf_ack held 1 -> all outputs at reset values in the same cycle; after release with ien=1, first subframe has pre=B.
